// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB register file with DEPTH registers of DATA_W bits.
// The response is registered. WAIT_CYCLES wait states are inserted per transfer.
// Accesses that are out of range or misaligned get PSLVERR.
// Optional feature: define APB_SLV_PSTRB_EN to add the PSTRB byte-lane write strobes.
module apb_slave_regfile #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int NBYTES = DATA_W / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  // Only the word-index bits may be set in a legal address.
  // This catches both out-of-range and misaligned addresses.
  // With DATA_W=8 there are no offset bits, so there is no alignment check.
  localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'((DEPTH - 1) << OFF_W);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic                write_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [NBYTES-1:0]   strb_reg;
  logic [NBYTES-1:0]   strb_in;
  logic [DATA_W-1:0]   mem_reg [DEPTH];

  logic [DATA_W-1:0]   prdata_reg;
  logic                pready_reg;
  logic                pslverr_reg;

  logic                setup;
  logic                capture;
  logic [ADDR_W-1:0]   addr_src;
  logic                write_src;
  logic [IDX_W-1:0]    idx_src;
  logic                err_src;
  logic                done_next;
  logic                wr_en;
  logic [NBYTES-1:0]   lane_we;

`ifdef APB_SLV_PSTRB_EN
  assign strb_in = PSTRB;
`else
  assign strb_in = '1;
`endif

  assign setup   = PSEL && !PENABLE;
  assign capture = (state_reg == IDLE) && setup;

  // With zero wait states, DONE is entered on the setup edge itself.
  // The address is therefore taken live from the bus in IDLE and from the latched copy afterwards.
  assign addr_src  = (state_reg == IDLE) ? PADDR  : addr_reg;
  assign write_src = (state_reg == IDLE) ? PWRITE : write_reg;
  assign idx_src   = addr_src[OFF_W +: IDX_W];
  assign err_src   = |(addr_src & ~IDX_MASK);
  assign done_next = (state_next == DONE);

  // The write commits on the edge that ends the PREADY cycle, and only if the master still holds the access phase.
  assign wr_en = (state_reg == DONE) && PSEL && PENABLE && write_reg && !err_src;

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign lane_we[gi] = wr_en & strb_reg[gi];
    end
  endgenerate

  // State and wait counter register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: setup, then wait states, then a single DONE cycle; dropping PSEL aborts the transfer
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (setup) begin
          if (WAIT_CYCLES == 0) begin
            state_next = DONE;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Latch the transfer attributes during the setup cycle
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      strb_reg  <= '0;
    end else if (capture) begin
      addr_reg  <= PADDR;
      write_reg <= PWRITE;
      wdata_reg <= PWDATA;
      strb_reg  <= strb_in;
    end
  end

  // Register array: cleared by reset, written one byte lane at a time
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int b = 0; b < NBYTES; b++) begin
        if (lane_we[b]) mem_reg[idx_src][8*b +: 8] <= wdata_reg[8*b +: 8];
      end
    end
  end

  // Registered response: valid only during the cycle spent in DONE
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
    end else begin
      pready_reg  <= done_next;
      pslverr_reg <= done_next && err_src;
      prdata_reg  <= (done_next && !write_src && !err_src) ? mem_reg[idx_src] : '0;
    end
  end

  assign PREADY  = pready_reg;
  assign PSLVERR = pslverr_reg;
  assign PRDATA  = prdata_reg;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed test of apb_slave_regfile.
// Three instances are tested, with WAIT_CYCLES = 0, 2 and 3.
// The instances share the bus, and each has its own PSEL.
// Define APB_SLV_PSTRB_EN to also run the byte-strobe checks.
module tb_apb_slave_regfile;

  logic        PCLK;
  logic        PRESET;
  logic [2:0]  psel;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  pstrb;
  wire  [2:0]  pready;
  wire  [2:0]  pslverr;
  wire  [31:0] prdata0, prdata1, prdata2;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] rdata;
  logic        err;
  int          lat;

  apb_slave_regfile #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata0), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_slave_regfile #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(2)) u_w2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata1), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_slave_regfile #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata2), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  function automatic logic [31:0] rd(input int d);
    case (d)
      0:       rd = prdata0;
      1:       rd = prdata1;
      default: rd = prdata2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer on instance d.
  // lat is the access cycle in which PREADY was seen; it is 0 if PREADY never came.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rdat, output logic erro, output int latency);
    latency = 0;
    rdat    = '0;
    erro    = 1'b0;
    @(posedge PCLK); #1;
    psel[d] = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; pstrb = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge PCLK);
      if (pready[d]) begin
        latency = c;
        rdat    = rd(d);
        erro    = pslverr[d];
        break;
      end
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1;
    psel[d] = 1'b0; PENABLE = 1'b0;
    $display("xfer dut=%0d %s addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
             d, wr ? "WR" : "RD", addr, data, rdat, erro, latency);
  endtask

  // After a transfer, the instance must be quiet: no PREADY and PRDATA = 0.
  task automatic idle_chk(input int d, input string tag);
    @(negedge PCLK);
    chk({tag, "_idle_pready"}, {31'd0, pready[d]}, 32'd0);
    chk({tag, "_idle_prdata"}, rd(d), 32'd0);
  endtask

  initial begin
    PRESET = 1'b1; psel = '0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; pstrb = 4'hF;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_pready%0d", d),  {31'd0, pready[d]},  32'd0);
      chk($sformatf("rst_pslverr%0d", d), {31'd0, pslverr[d]}, 32'd0);
      chk($sformatf("rst_prdata%0d", d),  rd(d), 32'd0);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    // Zero wait states: PREADY in the first access cycle
    xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rdata, err, lat);
    chk("w0_wr_lat", 32'(lat), 32'd1);
    chk("w0_wr_err", {31'd0, err}, 32'd0);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, rdata, err, lat);
    chk("w0_rd_lat", 32'(lat), 32'd1);
    chk("w0_rd_data", rdata, 32'hDEADBEEF);
    chk("w0_rd_err", {31'd0, err}, 32'd0);
    idle_chk(0, "w0");

    // Three wait states: PREADY in the fourth access cycle
    xfer(2, 1'b1, 32'h4, 32'hA5A55A5A, 4'hF, rdata, err, lat);
    chk("w3_wr_lat", 32'(lat), 32'd4);
    xfer(2, 1'b0, 32'h4, 32'h0, 4'hF, rdata, err, lat);
    chk("w3_rd_lat", 32'(lat), 32'd4);
    chk("w3_rd_data", rdata, 32'hA5A55A5A);
    chk("w3_rd_err", {31'd0, err}, 32'd0);
    idle_chk(2, "w3");

    // Error transfers: out of range, misaligned, high address bit
    xfer(0, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, rdata, err, lat);
    xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, rdata, err, lat);
    chk("oor_rd_lat", 32'(lat), 32'd1);
    chk("oor_rd_err", {31'd0, err}, 32'd1);
    chk("oor_rd_data", rdata, 32'd0);
    xfer(0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, rdata, err, lat);
    chk("mis_wr_lat", 32'(lat), 32'd1);
    chk("mis_wr_err", {31'd0, err}, 32'd1);
    xfer(0, 1'b0, 32'h80000004, 32'h0, 4'hF, rdata, err, lat);
    chk("hi_rd_err", {31'd0, err}, 32'd1);
    chk("hi_rd_data", rdata, 32'd0);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, rdata, err, lat);
    chk("reg1_kept", rdata, 32'hCAFEF00D);
    chk("reg1_kept_err", {31'd0, err}, 32'd0);

    // PSEL and PENABLE raised together in IDLE: the slave ignores this and does not write
    @(posedge PCLK); #1;
    psel[0] = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge PCLK);
      chk($sformatf("viol_pready_c%0d", c), {31'd0, pready[0]}, 32'd0);
    end
    @(posedge PCLK); #1;
    psel[0] = 1'b0; PENABLE = 1'b0;
    xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, rdata, err, lat);
    chk("viol_no_write", rdata, 32'hCAFEF00D);

    // Transfer aborted by dropping PSEL during wait states (two wait states)
    xfer(1, 1'b1, 32'hC, 32'h12345678, 4'hF, rdata, err, lat);
    chk("w2_wr_lat", 32'(lat), 32'd3);
    @(posedge PCLK); #1;
    psel[1] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC; PWDATA = 32'h55;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort_acc1_pready", {31'd0, pready[1]}, 32'd0);
    @(posedge PCLK); #1;
    psel[1] = 1'b0; PENABLE = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      chk($sformatf("abort_pready_c%0d", c), {31'd0, pready[1]}, 32'd0);
    end
    $display("abort dut=1 WR addr=0000000c wdata=00000055 (PSEL dropped)");
    xfer(1, 1'b0, 32'hC, 32'h0, 4'hF, rdata, err, lat);
    chk("abort_old_value", rdata, 32'h12345678);
    chk("abort_rd_lat", 32'(lat), 32'd3);

`ifdef APB_SLV_PSTRB_EN
    // Byte-lane strobes
    xfer(0, 1'b1, 32'h0, 32'h11223344, 4'hF, rdata, err, lat);
    xfer(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, rdata, err, lat);
    chk("strb_wr_err", {31'd0, err}, 32'd0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rdata, err, lat);
    chk("strb_merge", rdata, 32'h11BB33DD);
    xfer(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000, rdata, err, lat);
    chk("strb0_err", {31'd0, err}, 32'd0);
    chk("strb0_lat", 32'(lat), 32'd1);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rdata, err, lat);
    chk("strb0_noop", rdata, 32'h11BB33DD);
`endif

    // Reset during wait states on the three-wait instance
    @(posedge PCLK); #1;
    psel[2] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'hFFFF0000;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    #1 PRESET = 1'b1;
    #1;
    chk("rstwait_pready", {31'd0, pready[2]}, 32'd0);
    chk("rstwait_prdata", prdata2, 32'd0);
    psel[2] = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    $display("reset during WAIT on dut=2");
    xfer(2, 1'b0, 32'h4, 32'h0, 4'hF, rdata, err, lat);
    chk("rstwait_reg_cleared", rdata, 32'd0);
    chk("rstwait_first_lat", 32'(lat), 32'd4);
    xfer(1, 1'b0, 32'hC, 32'h0, 4'hF, rdata, err, lat);
    chk("rst_w2_reg_cleared", rdata, 32'd0);

    // Reset while the PREADY cycle is driving read data: outputs must clear before the next edge
    xfer(0, 1'b1, 32'h8, 32'h0BADF00D, 4'hF, rdata, err, lat);
    @(posedge PCLK); #1;
    psel[0] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h8;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("rstdone_pre_prdata", prdata0, 32'h0BADF00D);
    chk("rstdone_pre_pready", {31'd0, pready[0]}, 32'd1);
    #1 PRESET = 1'b1;
    #1;
    chk("rstdone_prdata", prdata0, 32'd0);
    chk("rstdone_pready", {31'd0, pready[0]}, 32'd0);
    chk("rstdone_pslverr", {31'd0, pslverr[0]}, 32'd0);
    psel[0] = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    $display("reset during DONE on dut=0");
    xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, rdata, err, lat);
    chk("rstdone_first_lat", 32'(lat), 32'd1);
    chk("rstdone_reg8_cleared", rdata, 32'd0);
    xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, rdata, err, lat);
    chk("rstdone_reg4_cleared", rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PADDR width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning PWDATA/PRDATA width; legal values are 8, 16 or 32.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning register count; legal values are powers of two from 2 to 256.
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 0, meaning wait states inserted per transfer; legal range is 0 to 15.
REQ-005 The block SHALL have port PCLK, input, width 1: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port PRESET, input, width 1: reset, asynchronous and active-high.
REQ-007 The block SHALL have port PSEL, input, width 1: slave select.
REQ-008 The block SHALL have port PENABLE, input, width 1: access phase.
REQ-009 The block SHALL have port PWRITE, input, width 1: 1 = write, 0 = read.
REQ-010 The block SHALL have port PADDR, input, width ADDR_W: byte address.
REQ-011 The block SHALL have port PWDATA, input, width DATA_W: write data.
REQ-012 The block SHALL have port PSTRB, input, width DATA_W/8: byte-lane write strobes; the port exists only when APB_SLV_PSTRB_EN is defined.
REQ-013 The block SHALL have port PRDATA, output, width DATA_W: registered read data.
REQ-014 The block SHALL have port PREADY, output, width 1: registered transfer-complete flag.
REQ-015 The block SHALL have port PSLVERR, output, width 1: registered error flag, valid only while PREADY=1.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-017 In IDLE with PSEL=1 and PENABLE=0 (setup), the block SHALL latch PADDR, PWRITE, PWDATA (and PSTRB) and go to DONE if WAIT_CYCLES=0, otherwise to WAIT with the counter loaded to WAIT_CYCLES.
REQ-018 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL go to DONE on the edge where the counter equals 1.
REQ-019 Timing: PREADY SHALL be 1 exactly in access cycle WAIT_CYCLES+1 after setup, for exactly one cycle; it SHALL be 0 in every other cycle.
REQ-020 DONE SHALL return to IDLE on the next edge, so back-to-back transfers need a new setup cycle.
REQ-021 Decode: word index = PADDR[log2(DATA_W/8) +: log2(DEPTH)].
REQ-022 An error SHALL be flagged when any PADDR bit at or above log2(DATA_W/8)+log2(DEPTH) is set (out of range), or when PADDR[log2(DATA_W/8)-1:0] != 0 (misaligned; this check does not apply when DATA_W=8).
REQ-023 On an error transfer: PSLVERR=1 together with PREADY, no register is modified, and PRDATA=0.
REQ-024 A valid write SHALL update the addressed register on the edge ending the PREADY=1 cycle, provided PSEL=1 and PENABLE=1 at that edge.
REQ-025 A valid read SHALL drive PRDATA from the addressed register in the PREADY=1 cycle; PRDATA SHALL be 0 in all other cycles.
REQ-026 Abort: if PSEL=0 in any cycle while in WAIT or DONE, the FSM SHALL return to IDLE with no write and PREADY=0 on the following cycle.
REQ-027 PSEL=1 and PENABLE=1 while in IDLE (protocol violation) SHALL be ignored; the FSM SHALL stay in IDLE.

Reset
REQ-028 Asserting PRESET SHALL immediately and asynchronously force: FSM=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, all DEPTH registers=0.
REQ-029 A reset asserted mid-transfer SHALL discard that transfer; no partial write SHALL occur.
REQ-030 The first setup cycle is honoured on the first rising edge after PRESET deasserts.

Configuration
REQ-031 With APB_SLV_PSTRB_EN defined, the block SHALL write only the byte lanes whose PSTRB bit is 1; PSTRB=0 with PWRITE=1 SHALL be a legal no-op write with PSLVERR=0.
REQ-032 With APB_SLV_PSTRB_EN undefined, the PSTRB port SHALL be absent and every valid write SHALL update all DATA_W bits.

Verification
REQ-033 Defaults, WAIT_CYCLES=0: write 0xDEADBEEF to PADDR 0x8, then read 0x8 -> PREADY=1 in the first access cycle; read returns 0xDEADBEEF; PSLVERR=0.
REQ-034 WAIT_CYCLES=3: write then read PADDR 0x4 -> PREADY is 0 for 3 access cycles and 1 on the 4th; data matches.
REQ-035 Read PADDR 0x40 (DEPTH=16), then write PADDR 0x6 -> PSLVERR=1 with PREADY on both; PRDATA=0; register 1 is unchanged.
REQ-036 WAIT_CYCLES=2: write 0x55 to PADDR 0xC, drop PSEL after the first access cycle -> no PREADY pulse; later read of 0xC returns the old value.
REQ-037 PRESET pulsed mid-WAIT after registers were loaded -> outputs 0 immediately; all registers read back 0.
REQ-038 APB_SLV_PSTRB_EN defined: register at 0x0 holds 0x11223344; write 0xAABBCCDD with PSTRB=4'b0101 -> read returns 0x11BB33DD.
